// File: rtl/maj_bist_ctrl.sv
// Exhaustive self-test sequencer for an external N-input majority block.
// Sweeps every input vector, compares y_dut against a popcount reference, and logs mismatches.
module maj_bist_ctrl #(
   parameter int unsigned N      = 25,
   parameter int unsigned THRESH = (N + 1) / 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic           y_dut,
   output logic [N-1:0]   x_out,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [15:0]    err_count,
   output logic [N-1:0]   first_fail_vec,
   output logic           first_fail_valid
);

   localparam int unsigned PW = $clog2(N + 1);
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    x_q, x_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     err_q, err_d;
   logic [N-1:0]    ffv_q, ffv_d;
   logic            ffvalid_q, ffvalid_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            busy_q, busy_d;

   logic [PW-1:0]   pop_c;
   logic            ref_c;
   logic            mismatch_c;

   // Reference majority: popcount of the applied vector against the threshold
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         pop_c = pop_c + PW'(x_q[i]);
      end
   end

   assign ref_c      = (pop_c >= PW'(THRESH));
   assign mismatch_c = y_dut ^ ref_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         x_q       <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         busy_q    <= busy_d;
      end
   end

   // Sequencing: abort outranks everything while busy, start outranks abort when idle/done
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      done_d    = done_q;
      pass_d    = pass_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               err_d     = '0;
               ffv_d     = '0;
               ffvalid_d = 1'b0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               x_d       = '0;
               cnt_d     = '0;
               state_d   = (SETTLE == 0) ? CHECK : HOLD;
            end
         end
         HOLD: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               if (mismatch_c) begin
                  err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                  if (!ffvalid_q) begin
                     ffv_d     = x_q;
                     ffvalid_d = 1'b1;
                  end
               end
               if (x_q == '1) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 16'd0);
               end else begin
                  x_d     = x_q + N'(1);
                  cnt_d   = '0;
                  state_d = (SETTLE == 0) ? CHECK : HOLD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            x_d     = '0;
         end
      endcase

      busy_d = (state_d == HOLD) || (state_d == CHECK);
   end

   assign x_out            = x_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// Scoreboard bench for maj_bist_ctrl: three instances (N=5/SETTLE=1, N=5/SETTLE=0, N=16 saturation).
// Stimulus queues the expected end-of-sweep result; per-instance monitors check it when busy drops.
module tb_maj_bist_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   mode;

   // Main instance: N=5, THRESH=3, SETTLE=1
   logic        start_m, abort_m, y_m, busy_m, done_m, pass_m, ffvalid_m;
   logic [4:0]  x_m, ffv_m;
   logic [15:0] err_m;
   // Zero-settle instance: N=5, THRESH=3, SETTLE=0
   logic        start_z, abort_z, y_z, busy_z, done_z, pass_z, ffvalid_z;
   logic [4:0]  x_z, ffv_z;
   logic [15:0] err_z;
   // Saturation instance: N=16, THRESH=17 (reference always 0), SETTLE=0, y stuck at 1
   logic        start_s, abort_s, y_s, busy_s, done_s, pass_s, ffvalid_s;
   logic [15:0] x_s, ffv_s;
   logic [15:0] err_s;

   typedef struct {
      string       name;
      logic        done;
      logic        pass;
      logic [15:0] err;
      logic [31:0] ffv;
      logic        ffvalid;
      logic [31:0] xo;
      int          cycles;
   } exp_t;

   exp_t q_m[$];
   exp_t q_z[$];
   exp_t q_s[$];
   int   n_total = 0;
   int   n_pass  = 0;

   always #5 clk = ~clk;

   maj_bist_ctrl #(.N(5), .THRESH(3), .SETTLE(1)) u_main (
      .clk(clk), .rst(rst), .start(start_m), .abort(abort_m), .y_dut(y_m),
      .x_out(x_m), .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
      .first_fail_vec(ffv_m), .first_fail_valid(ffvalid_m));

   maj_bist_ctrl #(.N(5), .THRESH(3), .SETTLE(0)) u_zero (
      .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .y_dut(y_z),
      .x_out(x_z), .busy(busy_z), .done(done_z), .pass(pass_z), .err_count(err_z),
      .first_fail_vec(ffv_z), .first_fail_valid(ffvalid_z));

   maj_bist_ctrl #(.N(16), .THRESH(17), .SETTLE(0)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .y_dut(y_s),
      .x_out(x_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
      .first_fail_vec(ffv_s), .first_fail_valid(ffvalid_s));

   // Majority block models: 0 = correct, 1 = stuck at 0, 2 = inverted
   always_comb begin
      case (mode)
         1:       y_m = 1'b0;
         2:       y_m = !($countones(x_m) >= 3);
         default: y_m = ($countones(x_m) >= 3);
      endcase
   end
   assign y_z     = ($countones(x_z) >= 3);
   assign y_s     = 1'b1;
   assign abort_z = 1'b0;
   assign abort_s = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
   endfunction

   function automatic void cmp_sweep(input exp_t e, input logic d, input logic p,
                                     input logic [15:0] er, input logic [31:0] fv,
                                     input logic fvl, input logic [31:0] xo, input int cyc);
      chk({e.name, ".done"},       32'(d),   32'(e.done));
      chk({e.name, ".pass"},       32'(p),   32'(e.pass));
      chk({e.name, ".err_count"},  32'(er),  32'(e.err));
      chk({e.name, ".ffv"},        fv,       e.ffv);
      chk({e.name, ".ffv_valid"},  32'(fvl), 32'(e.ffvalid));
      chk({e.name, ".x_out"},      xo,       e.xo);
      chk({e.name, ".busy_cycles"}, 32'(cyc), 32'(e.cycles));
   endfunction

   function automatic void exp_push(input int which, input string nm, input logic d, input logic p,
                                    input logic [15:0] er, input logic [31:0] fv, input logic fvl,
                                    input logic [31:0] xo, input int cyc);
      exp_t e;
      e.name = nm; e.done = d; e.pass = p; e.err = er; e.ffv = fv;
      e.ffvalid = fvl; e.xo = xo; e.cycles = cyc;
      case (which)
         1:       q_z.push_back(e);
         2:       q_s.push_back(e);
         default: q_m.push_back(e);
      endcase
   endfunction

   // Monitors: count busy cycles, and check the queued result when busy falls
   initial begin : mon_main
      int cyc; logic prev; exp_t e;
      cyc = 0; prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin prev = 1'b0; cyc = 0; end
         else begin
            if (busy_m) cyc++;
            if (prev && !busy_m) begin
               if (q_m.size() == 0) begin
                  n_total++;
                  $display("FAIL main.unexpected_end: got sweep end, expected none");
               end else begin
                  e = q_m.pop_front();
                  cmp_sweep(e, done_m, pass_m, err_m, 32'(ffv_m), ffvalid_m, 32'(x_m), cyc);
               end
               cyc = 0;
            end
            prev = busy_m;
         end
      end
   end

   initial begin : mon_zero
      int cyc; logic prev; exp_t e;
      cyc = 0; prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin prev = 1'b0; cyc = 0; end
         else begin
            if (busy_z) cyc++;
            if (prev && !busy_z) begin
               if (q_z.size() == 0) begin
                  n_total++;
                  $display("FAIL zero.unexpected_end: got sweep end, expected none");
               end else begin
                  e = q_z.pop_front();
                  cmp_sweep(e, done_z, pass_z, err_z, 32'(ffv_z), ffvalid_z, 32'(x_z), cyc);
               end
               cyc = 0;
            end
            prev = busy_z;
         end
      end
   end

   initial begin : mon_sat
      int cyc; logic prev; exp_t e;
      cyc = 0; prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin prev = 1'b0; cyc = 0; end
         else begin
            if (busy_s) cyc++;
            if (prev && !busy_s) begin
               if (q_s.size() == 0) begin
                  n_total++;
                  $display("FAIL sat.unexpected_end: got sweep end, expected none");
               end else begin
                  e = q_s.pop_front();
                  cmp_sweep(e, done_s, pass_s, err_s, 32'(ffv_s), ffvalid_s, 32'(x_s), cyc);
               end
               cyc = 0;
            end
            prev = busy_s;
         end
      end
   end

   // One-cycle start pulse (optionally with abort) on the selected instance
   task automatic pulse(input int which, input logic with_abort);
      @(posedge clk); #1;
      case (which)
         1:       start_z = 1'b1;
         2:       start_s = 1'b1;
         default: begin start_m = 1'b1; abort_m = with_abort; end
      endcase
      @(posedge clk); #1;
      start_m = 1'b0; start_z = 1'b0; start_s = 1'b0; abort_m = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q_m.size() == 0 && q_z.size() == 0 && q_s.size() == 0) break;
         @(posedge clk);
      end
      if (q_m.size() != 0 || q_z.size() != 0 || q_s.size() != 0) begin
         n_total++;
         $display("FAIL timeout: got %0d sweeps outstanding, expected 0",
                  q_m.size() + q_z.size() + q_s.size());
         q_m.delete(); q_z.delete(); q_s.delete();
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".x_out"},     32'(x_m),       32'h0);
      chk({nm, ".busy"},      32'(busy_m),    32'h0);
      chk({nm, ".done"},      32'(done_m),    32'h0);
      chk({nm, ".pass"},      32'(pass_m),    32'h0);
      chk({nm, ".err_count"}, 32'(err_m),     32'h0);
      chk({nm, ".ffv"},       32'(ffv_m),     32'h0);
      chk({nm, ".ffv_valid"}, 32'(ffvalid_m), 32'h0);
   endtask

   initial begin
      rst = 1'b1; mode = 0;
      start_m = 1'b0; abort_m = 1'b0; start_z = 1'b0; start_s = 1'b0;
      #3;
      chk_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Zero-settle sweep: one cycle per vector
      exp_push(1, "zero_settle", 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h1F, 32);
      pulse(1, 1'b0);
      drain(200);

      // Correct model, two cycles per vector
      mode = 0;
      exp_push(0, "correct", 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h1F, 64);
      pulse(0, 1'b0);
      drain(200);

      // Abort in DONE is ignored
      @(posedge clk); #1 abort_m = 1'b1;
      @(posedge clk); #1 abort_m = 1'b0;
      chk("done_abort.done",  32'(done_m), 32'h1);
      chk("done_abort.pass",  32'(pass_m), 32'h1);
      chk("done_abort.busy",  32'(busy_m), 32'h0);
      chk("done_abort.x_out", 32'(x_m),    32'h1F);

      // Start+abort together in DONE restarts; stuck-at-0 fails every vector with popcount>=3
      mode = 1;
      exp_push(0, "stuck0", 1'b1, 1'b0, 16'd16, 32'h07, 1'b1, 32'h1F, 64);
      pulse(0, 1'b1);
      drain(200);

      // Inverted model fails every vector
      mode = 2;
      exp_push(0, "inverted", 1'b1, 1'b0, 16'd32, 32'h00, 1'b1, 32'h1F, 64);
      pulse(0, 1'b0);
      drain(200);

      // Start held high through much of the sweep must not restart it
      mode = 0;
      exp_push(0, "start_held", 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h1F, 64);
      @(posedge clk); #1 start_m = 1'b1;
      repeat (31) @(posedge clk);
      #1 start_m = 1'b0;
      drain(200);

      // Abort sampled on the 20th edge after start; vector 7 already failed
      mode = 1;
      exp_push(0, "abort20", 1'b0, 1'b0, 16'd1, 32'h07, 1'b1, 32'h00, 20);
      pulse(0, 1'b0);
      repeat (19) @(posedge clk);
      #1 abort_m = 1'b1;
      @(posedge clk); #1 abort_m = 1'b0;
      chk("abort20.busy_now",  32'(busy_m), 32'h0);
      chk("abort20.x_now",     32'(x_m),    32'h0);
      chk("abort20.done_now",  32'(done_m), 32'h0);
      drain(50);

      // Restart from vector 0 after abort
      mode = 0;
      exp_push(0, "restart", 1'b1, 1'b1, 16'd0, 32'h0, 1'b0, 32'h1F, 64);
      pulse(0, 1'b0);
      drain(200);

      // Asynchronous reset between edges mid-sweep
      mode = 1;
      pulse(0, 1'b0);
      repeat (30) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_all_zero("mid_reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("post_reset.busy",  32'(busy_m), 32'h0);
      chk("post_reset.x_out", 32'(x_m),    32'h0);

      // 65536 mismatches: counter must saturate rather than wrap
      exp_push(2, "saturate", 1'b1, 1'b0, 16'hFFFF, 32'h0, 1'b1, 32'hFFFF, 65536);
      pulse(2, 1'b0);
      drain(70000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/maj_bist_ctrl.md
MAJ_BIST_CTRL -- requirements
Module: maj_bist_ctrl

Interface
REQ-001 SHALL have parameter N, default 25: width of the majority datapath under test (number of inputs x0..x(N-1)).
REQ-002 SHALL have parameter THRESH, default (N+1)/2: reference output is 1 when popcount(vector) >= THRESH.
REQ-003 SHALL have parameter SETTLE, default 1 (legal range 0..255): extra cycles each vector is held before the DUT output is sampled.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins an exhaustive sweep.
REQ-008 SHALL have port abort, input, 1 bit: terminates a sweep in progress.
REQ-009 SHALL have port y_dut, input, 1 bit: combinational output of the external majority block.
REQ-010 SHALL have port x_out, output, N bits: vector driven to the majority block inputs; bit i drives xi.
REQ-011 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-012 SHALL have port done, output, 1 bit: high after a sweep completes; held until the next start or reset.
REQ-013 SHALL have port pass, output, 1 bit: valid when done=1; 1 when err_count==0.
REQ-014 SHALL have port err_count, output, 16 bits: number of mismatching vectors, saturating.
REQ-015 SHALL have port first_fail_vec, output, N bits: first vector that mismatched.
REQ-016 SHALL have port first_fail_valid, output, 1 bit: first_fail_vec holds a captured vector.

Function
REQ-017 SHALL implement the FSM states IDLE, HOLD, CHECK and DONE.
REQ-018 IDLE + start=1 SHALL clear err_count, first_fail_valid, first_fail_vec and done, set x_out=0, and go to HOLD (or to CHECK if SETTLE=0).
REQ-019 HOLD SHALL count SETTLE cycles with x_out held stable, then go to CHECK.
REQ-020 CHECK SHALL last one cycle; each vector SHALL therefore occupy exactly SETTLE+1 cycles.
REQ-021 At the CHECK edge, y_dut SHALL be compared with ref = (popcount(x_out) >= THRESH).
  - Popcount width: clog2(N+1) bits; computed combinationally from x_out.
REQ-022 On a mismatch, err_count SHALL increment, saturating at 16'hFFFF; if first_fail_valid=0, x_out SHALL be captured into first_fail_vec and first_fail_valid set.
REQ-023 CHECK with x_out != all-ones SHALL increment x_out by 1 and return to HOLD (or stay in CHECK if SETTLE=0).
REQ-024 CHECK with x_out == all-ones SHALL perform the final compare, go to DONE, keep x_out at all-ones, and set done=1 and pass=(final err_count==0).
REQ-025 A full sweep SHALL take 2^N*(SETTLE+1) cycles from the start edge to the assertion of done.
REQ-026 busy SHALL be 1 in HOLD and CHECK and 0 in IDLE and DONE.
REQ-027 DONE + start=1 SHALL behave as IDLE + start=1 (restart the sweep).
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort while busy=1 SHALL go to IDLE on the next edge, with done=0, pass=0 and x_out=0; err_count and first_fail_* SHALL be retained. abort in IDLE or DONE SHALL have no effect.
REQ-030 If abort and start are asserted in the same cycle, abort SHALL have priority while busy; start SHALL have priority in IDLE and DONE.
REQ-031 An abort coinciding with the final CHECK SHALL win: no DONE state and done=0.
REQ-032 err_count SHALL remain 16'hFFFF once saturated, and pass SHALL be 0.

Reset
REQ-033 rst=1 SHALL asynchronously force state=IDLE, x_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0 and first_fail_valid=0, including mid-sweep.
REQ-034 After rst is deasserted, the block SHALL wait in IDLE for start.

Verification
REQ-035 N=5, SETTLE=1, correct majority model on y_dut, start pulse -> done=1 exactly 64 cycles later, pass=1, err_count=0, first_fail_valid=0.
REQ-036 N=5, THRESH=3, y_dut stuck at 0 -> err_count=16, first_fail_vec=5'b00111, pass=0.
REQ-037 N=5, y_dut inverted majority -> err_count=32, first_fail_vec=5'b00000; N=5, SETTLE=0 with correct model -> done after 32 cycles.
REQ-038 N=5, abort at cycle 20 -> busy=0 on the next edge, x_out=0, done=0; a later start restarts from vector 0 and reaches pass=1.
REQ-039 rst asserted mid-sweep, asynchronously between edges -> all outputs 0 immediately; start held during busy -> no restart and no change in sweep length.
REQ-040 N=17, THRESH=9, y_dut stuck at 0 (65536 mismatches) -> err_count=16'hFFFF (saturated), pass=0, first_fail_vec=17'h001FF.
